// File: rtl/fcs_pkg.sv
// Shared constants and state type for the Ethernet FCS transmit/receive path.
// Build option: FCS_TX_PAD_EN adds the PAD state (minimum-frame padding).
package fcs_pkg;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [10:0] MIN_FRAME     = 11'd60;

`ifdef FCS_TX_PAD_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2,
    ST_FCS  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FCS  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/fcs_crc32_byte.sv
// Combinational CRC-32 (reflected, LSB first) advance by one byte.
// Shared between the transmit appender and the receive-side checker.
module fcs_crc32_byte
  import fcs_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c_s;

  // Eight shift/xor steps of the reflected polynomial.
  always_comb begin
    c_s = crc_i ^ {24'h00_0000, data_i};
    for (int i = 0; i < 8; i++) begin
      if (c_s[0]) begin
        c_s = {1'b0, c_s[31:1]} ^ CRC_POLY_REFL;
      end else begin
        c_s = {1'b0, c_s[31:1]};
      end
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/fcs_tx_append.sv
// Appends a 4-byte Ethernet FCS to a byte stream behind one output register.
// Build option: FCS_TX_PAD_EN pads short frames with 0x00 to 60 bytes first.
module fcs_tx_append
  import fcs_pkg::*;
(
  input  logic       pclk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       sof_i,
  input  logic       eof_i,
  input  logic       val_i,
  output logic       rdy_o,
  output logic [7:0] data_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       val_o,
  input  logic       rdy_i,
  output logic       err_o
);

  state_e      state_q, state_d, eof_state_s;
  logic [31:0] crc_q, crc_d, crc_in_s, crc_next_s, fcs_s;
  logic [10:0] cnt_q, cnt_d, cnt_inc_s;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d, crc_byte_s;
  logic        sof_q, sof_d, eof_q, eof_d, val_q, val_d, err_q, err_d;
  logic        load_s, rdy_s, acc_s;

  // The output register may take a new byte when empty or being drained.
  assign load_s     = !val_q || rdy_i;
  assign rdy_s      = load_s && ((state_q == ST_IDLE) || (state_q == ST_DATA));
  assign acc_s      = val_i && rdy_s;
  assign crc_in_s   = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
  assign crc_byte_s = ((state_q == ST_IDLE) || (state_q == ST_DATA)) ? data_i : 8'h00;
  assign cnt_inc_s  = (cnt_q == 11'h7FF) ? cnt_q : (cnt_q + 11'd1);
  assign fcs_s      = ~crc_q;

`ifdef FCS_TX_PAD_EN
  logic [10:0] end_cnt_s;
  assign end_cnt_s   = (state_q == ST_IDLE) ? 11'd1 : cnt_inc_s;
  assign eof_state_s = (end_cnt_s < MIN_FRAME) ? ST_PAD : ST_FCS;
`else
  assign eof_state_s = ST_FCS;
`endif

  fcs_crc32_byte u_crc (
    .crc_i  (crc_in_s),
    .data_i (crc_byte_s),
    .crc_o  (crc_next_s)
  );

  // Next-state and output-register load logic.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    val_d   = val_q;
    err_d   = 1'b0;
    if (load_s) begin
      val_d = 1'b0;
      sof_d = 1'b0;
      eof_d = 1'b0;
    end else begin
      val_d = val_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (acc_s && sof_i) begin
          data_d  = data_i;
          sof_d   = 1'b1;
          val_d   = 1'b1;
          crc_d   = crc_next_s;
          cnt_d   = 11'd1;
          idx_d   = 2'd0;
          state_d = eof_i ? eof_state_s : ST_DATA;
        end else if (acc_s) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (acc_s) begin
          data_d  = data_i;
          val_d   = 1'b1;
          err_d   = sof_i;
          crc_d   = crc_next_s;
          cnt_d   = cnt_inc_s;
          state_d = eof_i ? eof_state_s : ST_DATA;
        end else begin
          err_d = 1'b0;
        end
      end
`ifdef FCS_TX_PAD_EN
      ST_PAD: begin
        if (load_s) begin
          data_d  = 8'h00;
          val_d   = 1'b1;
          crc_d   = crc_next_s;
          cnt_d   = cnt_inc_s;
          state_d = (cnt_inc_s >= MIN_FRAME) ? ST_FCS : ST_PAD;
        end else begin
          state_d = ST_PAD;
        end
      end
`endif
      ST_FCS: begin
        // Leaving FCS as the last byte loads lets the next frame start without a gap.
        if (load_s) begin
          data_d = fcs_s[{idx_q, 3'b000} +: 8];
          val_d  = 1'b1;
          eof_d  = (idx_q == 2'd3);
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            crc_d   = CRC_INIT;
          end else begin
            state_d = ST_FCS;
          end
        end else begin
          state_d = ST_FCS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= 11'd0;
      idx_q   <= 2'd0;
      data_q  <= 8'h00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign rdy_o  = rdy_s;
  assign data_o = data_q;
  assign sof_o  = sof_q;
  assign eof_o  = eof_q;
  assign val_o  = val_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_fcs_tx_append.sv
// Randomised self-checking bench for fcs_tx_append against a bit-serial,
// MSB-first CRC model; honours FCS_TX_PAD_EN when defined.
`timescale 1ns/1ps
module tb_fcs_tx_append;

  typedef logic [7:0] bq_t[$];

  logic       pclk_i = 1'b0;
  logic       rst_i, sof_i, eof_i, val_i, rdy_i;
  logic [7:0] data_i;
  logic       rdy_o, sof_o, eof_o, val_o, err_o;
  logic [7:0] data_o;

  fcs_tx_append dut (
    .pclk_i (pclk_i), .rst_i (rst_i), .data_i (data_i), .sof_i (sof_i),
    .eof_i  (eof_i),  .val_i (val_i), .rdy_o  (rdy_o),  .data_o (data_o),
    .sof_o  (sof_o),  .eof_o (eof_o), .val_o  (val_o),  .rdy_i  (rdy_i),
    .err_o  (err_o)
  );

  always #5 pclk_i = ~pclk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_mode = 0;
  int cyc = 0, err_cnt = 0, rdy_low_cnt = 0, eof_cnt = 0, xfer_cnt = 0;
  bq_t obs_q;
  bit  obs_sof[$], obs_eof[$];
  int  obs_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Textbook MSB-first CRC register fed the bits of each byte LSB first.
  function automatic logic [31:0] crc_nr(input bq_t q);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < q.size(); k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ q[k][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    end
    return c;
  endfunction

  function automatic bq_t expected(input bq_t pl);
    bq_t         e;
    logic [31:0] f;
    e = pl;
`ifdef FCS_TX_PAD_EN
    while (e.size() < 60) e.push_back(8'h00);
`endif
    f = ~rev32(crc_nr(e));
    for (int i = 0; i < 4; i++) e.push_back(f[8*i +: 8]);
    return e;
  endfunction

  // Output monitor: records transfers, checks stall hold, counts events.
  initial begin
    logic        prev_stall;
    logic [10:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = 11'h000;
    forever begin
      @(negedge pclk_i);
      cyc++;
      if (!rst_i) begin
        if (err_o) err_cnt++;
        if (!rdy_o) rdy_low_cnt++;
        if (prev_stall) check("hold", {21'h0, val_o, sof_o, eof_o, data_o}, {21'h0, prev_out});
        if (val_o && rdy_i) begin
          obs_q.push_back(data_o);
          obs_sof.push_back(sof_o);
          obs_eof.push_back(eof_o);
          obs_cyc.push_back(cyc);
          xfer_cnt++;
          if (eof_o) eof_cnt++;
        end
        prev_stall = val_o && !rdy_i;
        prev_out   = {val_o, sof_o, eof_o, data_o};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge pclk_i);
    #1;
    case (stall_mode)
      0:       rdy_i = 1'b1;
      1:       rdy_i = ~rdy_i;
      default: rdy_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_frame(input bq_t pl, input int mid_sof);
    bit acc;
    int guard;
    for (int i = 0; i < pl.size(); i++) begin
      data_i = pl[i];
      sof_i  = (i == 0) || (i == mid_sof);
      eof_i  = (i == pl.size() - 1);
      val_i  = 1'b1;
      acc    = 1'b0;
      guard  = 0;
      while (!acc && guard < 300) begin
        @(negedge pclk_i);
        acc = rdy_o;
        step();
        guard++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
    val_i = 1'b0;
    sof_i = 1'b0;
    eof_i = 1'b0;
  endtask

  task automatic run_frame(input bq_t pl, input int mid_sof, input int mode);
    bq_t exp;
    int  target, guard, n_sof, n_eof, last;
    exp = expected(pl);
    stall_mode = mode;
    obs_q.delete(); obs_sof.delete(); obs_eof.delete(); obs_cyc.delete();
    target = eof_cnt + 1;
    send_frame(pl, mid_sof);
    guard = 0;
    while (eof_cnt < target && guard < 2000) begin
      step();
      guard++;
    end
    check("frame_done", eof_cnt, target);
    check("len", obs_q.size(), exp.size());
    n_sof = 0;
    n_eof = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (i < exp.size()) check("byte", {24'h0, obs_q[i]}, {24'h0, exp[i]});
      n_sof += int'(obs_sof[i]);
      n_eof += int'(obs_eof[i]);
    end
    last = obs_q.size() - 1;
    check("sof_count", n_sof, 1);
    check("eof_count", n_eof, 1);
    if (last >= 0) begin
      check("sof_first", obs_sof[0], 1);
      check("eof_last", obs_eof[last], 1);
    end else begin
      check("no_output", 32'd0, 32'd1);
    end
    check("residue", rev32(crc_nr(obs_q)), 32'hDEBB_20E3);
  endtask

  initial begin
    bq_t pl;
    int  e0, x0, eo0, n;
    rst_i = 1'b1; val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; data_i = 8'h00; rdy_i = 1'b1;
    stall_mode = 0;
    repeat (3) step();
    @(negedge pclk_i);
    check("rst_val", val_o, 0);
    check("rst_sof", sof_o, 0);
    check("rst_eof", eof_o, 0);
    check("rst_err", err_o, 0);
    check("rst_data", data_o, 0);
    step();
    rst_i = 1'b0;
    @(negedge pclk_i);
    check("rst_rdy", rdy_o, 1);
    step();

    // "123456789", no stalls
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    run_frame(pl, -1, 0);
`ifndef FCS_TX_PAD_EN
    check("fcs0", obs_q[9], 8'h26);
    check("fcs1", obs_q[10], 8'h39);
    check("fcs2", obs_q[11], 8'hF4);
    check("fcs3", obs_q[12], 8'hCB);
    check("eof_on_cb", obs_eof[12], 1);
    check("cycles13", obs_cyc[obs_cyc.size()-1] - obs_cyc[0] + 1, 13);
`endif

    // same frame with rdy_i toggling every cycle
    run_frame(pl, -1, 1);

    // one-byte 0x00 frame: rdy_o stays low until the last output byte is loaded
    pl.delete();
    pl.push_back(8'h00);
    stall_mode = 0;
    step();
    rdy_low_cnt = 0;
    run_frame(pl, -1, 0);
    repeat (3) step();
    check("rdy_low", rdy_low_cnt, expected(pl).size() - 1);

    // stray byte in IDLE: dropped with one err pulse
    stall_mode = 0;
    e0 = err_cnt;
    x0 = xfer_cnt;
    data_i = 8'hA5; sof_i = 1'b0; eof_i = 1'b0; val_i = 1'b1;
    @(negedge pclk_i);
    check("idle_rdy", rdy_o, 1);
    step();
    val_i = 1'b0;
    repeat (4) step();
    check("idle_err", err_cnt - e0, 1);
    check("idle_drop", xfer_cnt - x0, 0);

    // sof inside a frame: forwarded as data with an err pulse
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    e0 = err_cnt;
    run_frame(pl, 3, 0);
    check("midsof_err", err_cnt - e0, 1);

    // reset while the second FCS byte sits in the output register
    pl.delete();
    for (int i = 0; i < 70; i++) pl.push_back(8'($urandom));
    n = pl.size();
    stall_mode = 0;
    eo0 = eof_cnt;
    send_frame(pl, -1);
    step();
    step();
    rst_i = 1'b1;
    rdy_i = 1'b0;
    @(negedge pclk_i);
    check("pend_val", val_o, 1);
    check("pend_fcs1", data_o, expected(pl)[n+1]);
    @(posedge pclk_i);
    #1;
    rst_i = 1'b0;
    @(negedge pclk_i);
    check("midrst_val", val_o, 0);
    check("midrst_idle", rdy_o, 1);
    check("midrst_noeof", eof_cnt - eo0, 0);
    step();
    pl.delete();
    for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
    run_frame(pl, -1, 0);

    // random frames with random stall patterns
    for (int f = 0; f < 8; f++) begin
      pl.delete();
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_frame(pl, -1, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
